// File: rtl/div4_inv_ctrl.sv
// rtl/div4_inv_ctrl.sv - radix-4 modular inversion loop sequencer for the BLS12-381 inverter
// Optional iteration cap: define INV_ITER_LIMIT_EN.
module div4_inv_ctrl #(
  parameter int WORD_SIZE = 381,
  parameter int DW        = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] a_low,
  input  logic [1:0] b_low,
  input  logic       a_is_zero,
  input  logic       sign_flag,
  output logic       dp_load,
  output logic [2:0] dp_op,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [9:0] iter_count
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ITER, S_FINAL, S_DONE} state_t;

  localparam logic [2:0] OP_HOLD    = 3'd0;
  localparam logic [2:0] OP_SHR4    = 3'd1;
  localparam logic [2:0] OP_SHR2    = 3'd2;
  localparam logic [2:0] OP_SUB4    = 3'd3;
  localparam logic [2:0] OP_ADD4    = 3'd4;
  localparam logic [2:0] OP_SWPSUB4 = 3'd5;
  localparam logic [2:0] OP_SWPADD4 = 3'd6;
  localparam logic [2:0] OP_FIX     = 3'd7;

  localparam int         ITER_LIMIT   = 2 * WORD_SIZE + 4;
  localparam logic [9:0] ITER_LIMIT_W = 10'(ITER_LIMIT);

  state_t          state, state_n;
  logic [DW-1:0]   delta, delta_n;
  logic            first, first_n;
  logic            err_n;
  logic [9:0]      iter_n;
  logic            issue;
  logic [1:0]      low_sum;
  logic            at_limit;
  logic            unused_bits;

  assign low_sum  = a_low + b_low;
  assign at_limit = (iter_count >= ITER_LIMIT_W);

  // sign_flag only steers the datapath during FIX; the controller just issues FIX.
`ifdef INV_ITER_LIMIT_EN
  assign unused_bits = sign_flag;
`else
  assign unused_bits = sign_flag ^ at_limit;
`endif

  always_comb begin
    state_n = state;
    dp_op   = OP_HOLD;
    delta_n = delta;
    first_n = first;
    err_n   = err;
    iter_n  = iter_count;
    issue   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_LOAD;
          iter_n  = '0;
          err_n   = 1'b0;
          delta_n = '0;
        end
      end
      S_LOAD: begin
        first_n = 1'b1;
        state_n = S_ITER;
      end
      S_ITER: begin
        if (a_is_zero && first) begin
          err_n   = 1'b1;
          state_n = S_DONE;
        end else if (a_is_zero) begin
          state_n = S_FINAL;
`ifdef INV_ITER_LIMIT_EN
        end else if (at_limit) begin
          err_n   = 1'b1;
          state_n = S_DONE;
`endif
        end else if (a_low == 2'b00) begin
          dp_op   = OP_SHR4;
          delta_n = delta - DW'(2);
          issue   = 1'b1;
        end else if (a_low == 2'b10) begin
          dp_op   = OP_SHR2;
          delta_n = delta - DW'(1);
          issue   = 1'b1;
        end else begin
          // Both odd: A+B divisible by 4 means adding clears the two low bits.
          issue = 1'b1;
          if (!delta[DW-1]) begin
            dp_op = (low_sum == 2'b00) ? OP_ADD4 : OP_SUB4;
          end else begin
            dp_op   = (low_sum == 2'b00) ? OP_SWPADD4 : OP_SWPSUB4;
            delta_n = -delta;
          end
        end
        if (issue) begin
          first_n = 1'b0;
          if (iter_count != 10'h3FF) iter_n = iter_count + 10'd1;
        end
      end
      S_FINAL: begin
        dp_op   = OP_FIX;
        state_n = S_DONE;
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      delta      <= '0;
      first      <= 1'b0;
      err        <= 1'b0;
      iter_count <= '0;
      dp_load    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      delta      <= delta_n;
      first      <= first_n;
      err        <= err_n;
      iter_count <= iter_n;
      dp_load    <= (state_n == S_LOAD);
      busy       <= (state_n == S_LOAD) || (state_n == S_ITER) || (state_n == S_FINAL);
      done       <= (state_n == S_DONE);
    end
  end

endmodule
